// File: rtl/rotation_column_scheduler_if.sv
// rotation_column_scheduler_if: index input and column timing outputs of the rotation scheduler.
interface rotation_column_scheduler_if #(
   parameter int CNT_WIDTH = 24,
   parameter int COL_BITS  = 7
);
   logic                 enable_i;
   logic                 beam_clean_i;
   logic [COL_BITS-1:0]  col_idx_o;
   logic                 col_stb_o;
   logic                 frame_stb_o;
   logic                 locked_o;
   logic [CNT_WIDTH-1:0] period_o;
   logic                 reject_o;
   modport master (
      output enable_i, beam_clean_i,
      input  col_idx_o, col_stb_o, frame_stb_o, locked_o, period_o, reject_o
   );
   modport slave (
      input  enable_i, beam_clean_i,
      output col_idx_o, col_stb_o, frame_stb_o, locked_o, period_o, reject_o
   );
endinterface

// File: rtl/rotation_column_scheduler.sv
// rotation_column_scheduler: measures the revolution period from index edges and
// divides it into 2**COL_BITS column strobes; the last column absorbs the remainder.
module rotation_column_scheduler #(
   parameter int CNT_WIDTH  = 24,
   parameter int COL_BITS   = 7,
   parameter int MIN_PERIOD = 4096,
   parameter int MAX_PERIOD = 2**24-1
) (
   input logic clk,
   input logic rst_n,
   rotation_column_scheduler_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ARM  = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;
   localparam logic [CNT_WIDTH-1:0] MIN_P = CNT_WIDTH'(MIN_PERIOD);
   localparam logic [CNT_WIDTH-1:0] MAX_P = CNT_WIDTH'(MAX_PERIOD);
   localparam int TW = CNT_WIDTH - COL_BITS;
   logic [1:0]           state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_p1, period_q, period_d;
   logic [TW-1:0]        col_per_q, col_per_d, tmr_q, tmr_d;
   logic [COL_BITS-1:0]  col_q, col_d;
   logic                 beam_q, col_stb_q, col_stb_d, frame_q, frame_d;
   logic                 rej_q, rej_d, locked_q, locked_d;
   logic                 edge_w, acc_w, tout_w;
   assign cnt_p1 = cnt_q + 1'b1;
   assign edge_w = bus.beam_clean_i & ~beam_q;
   assign acc_w  = edge_w & (cnt_p1 >= MIN_P) & (state_q != IDLE);
   assign tout_w = cnt_p1 == MAX_P;
   always_comb begin
      state_d   = state_q;
      cnt_d     = tout_w ? cnt_q : cnt_p1;
      period_d  = period_q;
      col_per_d = col_per_q;
      col_d     = col_q;
      tmr_d     = tmr_q;
      col_stb_d = 1'b0;
      frame_d   = 1'b0;
      rej_d     = 1'b0;
      if (!bus.enable_i) begin
         state_d   = IDLE;
         cnt_d     = '0;
         period_d  = '0;
         col_per_d = '0;
         col_d     = '0;
         tmr_d     = '0;
      end else if (state_q == IDLE) begin
         cnt_d   = '0;
         state_d = edge_w ? ARM : IDLE;
      end else if (acc_w) begin
         // accepted edge outranks both column expiry and timeout
         state_d   = RUN;
         cnt_d     = '0;
         period_d  = cnt_p1;
         col_per_d = cnt_p1[CNT_WIDTH-1:COL_BITS];
         tmr_d     = cnt_p1[CNT_WIDTH-1:COL_BITS] - 1'b1;
         col_d     = '0;
         col_stb_d = 1'b1;
         frame_d   = 1'b1;
      end else begin
         rej_d = edge_w;
         if (tout_w) begin
            state_d  = IDLE;
            period_d = '0;
            col_d    = '0;
            tmr_d    = '0;
         end else if (state_q == RUN) begin
            if (tmr_q != '0) begin
               tmr_d = tmr_q - 1'b1;
            end else if (col_q != '1) begin
               col_d     = col_q + 1'b1;
               col_stb_d = 1'b1;
               tmr_d     = col_per_q - 1'b1;
            end
         end
      end
      locked_d = state_d == RUN;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         period_q  <= '0;
         col_per_q <= '0;
         tmr_q     <= '0;
         col_q     <= '0;
         beam_q    <= 1'b1;
         col_stb_q <= 1'b0;
         frame_q   <= 1'b0;
         rej_q     <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         col_per_q <= col_per_d;
         tmr_q     <= tmr_d;
         col_q     <= col_d;
         beam_q    <= bus.beam_clean_i;
         col_stb_q <= col_stb_d;
         frame_q   <= frame_d;
         rej_q     <= rej_d;
         locked_q  <= locked_d;
      end
   end
   assign bus.col_idx_o   = col_q;
   assign bus.col_stb_o   = col_stb_q;
   assign bus.frame_stb_o = frame_q;
   assign bus.locked_o    = locked_q;
   assign bus.period_o    = period_q;
   assign bus.reject_o    = rej_q;
endmodule

// File: tb/tb_rotation_column_scheduler.sv
// tb_rotation_column_scheduler: edge-table vectors, hand sequences and random index
// gaps checked every cycle against a timestamp-based reference model.
module tb_rotation_column_scheduler;
   localparam int CW = 24;
   localparam int CB = 3;
   localparam int MINP = 16;
   localparam int MAXP = 1000;
   localparam int NC = 2**CB;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   int n = 0, t = 0, per = 0, cp = 0, mode = 0;
   bit pb = 1'b1, e_fs = 1'b0, e_rj = 1'b0;
   rotation_column_scheduler_if #(.CNT_WIDTH(CW), .COL_BITS(CB)) bus ();
   rotation_column_scheduler #(
      .CNT_WIDTH(CW), .COL_BITS(CB), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );
   always #5 clk = ~clk;
   typedef struct {
      int gap;
      bit frame;
      bit rej;
      int period;
      bit locked;
      int col;
   } vec_t;
   vec_t vecs[12];
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, n, act, exp);
      end
   endtask
   // Model: outputs follow from the time since the last accepted edge, not from counters.
   task automatic model_step(input bit en, input bit b);
      bit e;
      int g;
      e = b & ~pb;
      pb = b;
      e_fs = 1'b0;
      e_rj = 1'b0;
      g = n - t;
      if (!en) mode = 0;
      else if (mode == 0) begin
         if (e) begin mode = 1; t = n; end
      end else if (e && g >= MINP) begin
         mode = 2; t = n; per = g; cp = g / NC; e_fs = 1'b1;
      end else begin
         e_rj = e;
         if (g >= MAXP) mode = 0;
      end
   endtask
   task automatic model_check();
      int d, ei, es;
      d = n - t;
      ei = 0;
      es = 0;
      if (mode == 2) begin
         ei = (d / cp > NC - 1) ? NC - 1 : d / cp;
         es = (d % cp == 0 && d / cp <= NC - 1) ? 1 : 0;
      end
      chk("model col_idx", int'(bus.col_idx_o), ei);
      chk("model col_stb", int'(bus.col_stb_o), es);
      chk("model frame_stb", int'(bus.frame_stb_o), int'(e_fs));
      chk("model reject", int'(bus.reject_o), int'(e_rj));
      chk("model locked", int'(bus.locked_o), mode == 2 ? 1 : 0);
      chk("model period", int'(bus.period_o), mode == 2 ? per : 0);
   endtask
   task automatic cyc(input bit en, input bit b);
      bus.enable_i = en;
      bus.beam_clean_i = b;
      @(posedge clk);
      n++;
      model_step(en, b);
      @(negedge clk);
      model_check();
   endtask
   task automatic gap_edge(input int g);
      for (int i = 0; i < g - 1; i++) cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b1);
   endtask
   task automatic model_reset();
      mode = 0;
      pb = 1'b1;
      e_fs = 1'b0;
      e_rj = 1'b0;
   endtask
   initial begin
      int k;
      vecs = '{
         '{20, 0, 0,  0, 0, 0},
         '{80, 1, 0, 80, 1, 0},
         '{80, 1, 0, 80, 1, 0},
         '{84, 1, 0, 84, 1, 0},
         '{84, 1, 0, 84, 1, 0},
         '{80, 1, 0, 80, 1, 0},
         '{ 5, 0, 1, 80, 1, 0},
         '{75, 1, 0, 80, 1, 0},
         '{64, 1, 0, 64, 1, 0},
         '{64, 1, 0, 64, 1, 0},
         '{10, 0, 1, 64, 1, 1},
         '{54, 1, 0, 64, 1, 0}
      };
      bus.enable_i = 1'b1;
      bus.beam_clean_i = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset col_idx", int'(bus.col_idx_o), 0);
      chk("reset col_stb", int'(bus.col_stb_o), 0);
      chk("reset frame_stb", int'(bus.frame_stb_o), 0);
      chk("reset locked", int'(bus.locked_o), 0);
      chk("reset period", int'(bus.period_o), 0);
      chk("reset reject", int'(bus.reject_o), 0);
      rst_n = 1'b1;
      repeat (50) cyc(1'b1, 1'b1);
      chk("beam high locked", int'(bus.locked_o), 0);
      chk("beam high period", int'(bus.period_o), 0);
      foreach (vecs[i]) begin
         gap_edge(vecs[i].gap);
         chk($sformatf("vec%0d frame_stb", i), int'(bus.frame_stb_o), int'(vecs[i].frame));
         chk($sformatf("vec%0d col_stb", i), int'(bus.col_stb_o), int'(vecs[i].frame));
         chk($sformatf("vec%0d reject", i), int'(bus.reject_o), int'(vecs[i].rej));
         chk($sformatf("vec%0d period", i), int'(bus.period_o), vecs[i].period);
         chk($sformatf("vec%0d locked", i), int'(bus.locked_o), int'(vecs[i].locked));
         chk($sformatf("vec%0d col_idx", i), int'(bus.col_idx_o), vecs[i].col);
      end
      k = 0;
      do begin
         cyc(1'b1, 1'b0);
         k++;
      end while (bus.locked_o && k < 1100);
      chk("timeout cycles", k, MAXP);
      chk("timeout col_idx", int'(bus.col_idx_o), 0);
      chk("timeout period", int'(bus.period_o), 0);
      gap_edge(30);
      gap_edge(80);
      chk("pre-disable locked", int'(bus.locked_o), 1);
      repeat (35) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      chk("disable locked", int'(bus.locked_o), 0);
      chk("disable period", int'(bus.period_o), 0);
      chk("disable col_idx", int'(bus.col_idx_o), 0);
      repeat (3) cyc(1'b1, 1'b0);
      gap_edge(40);
      chk("relock1 locked", int'(bus.locked_o), 0);
      gap_edge(80);
      chk("relock2 locked", int'(bus.locked_o), 1);
      chk("relock2 period", int'(bus.period_o), 80);
      repeat (25) cyc(1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("async rst col_idx", int'(bus.col_idx_o), 0);
      chk("async rst locked", int'(bus.locked_o), 0);
      chk("async rst period", int'(bus.period_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      gap_edge(30);
      chk("rst relock1 locked", int'(bus.locked_o), 0);
      gap_edge(72);
      chk("rst relock2 locked", int'(bus.locked_o), 1);
      chk("rst relock2 period", int'(bus.period_o), 72);
      for (int i = 0; i < 60; i++) begin
         int r, g;
         r = $urandom_range(0, 19);
         if (r == 0) cyc(1'b0, 1'b0);
         g = (r < 3) ? $urandom_range(990, 1010) :
             (r < 6) ? $urandom_range(2, 15) : $urandom_range(16, 140);
         gap_edge(g);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
